// File: rtl/battleship_input_cond_pkg.sv
// Shared types and constants for the battleship board-input front end.
package battleship_input_cond_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int DB_CYCLES_DEF   = 3;
  localparam int CLK_HZ          = 50;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    PRESSED    = 2'd2,
    RELEASE_DB = 2'd3
  } btn_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes and debounces one button, emitting a single-cycle pulse per accepted press.
// Latency: SYNC_STAGES+DB_CYCLES+1 edges from raw rise to pulse; no backpressure.
module btn_debounce
  import battleship_input_cond_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse,
  output logic press_db
);

  localparam int CW = $clog2(DB_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  btn_state_e             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   pulse_d;

  assign s        = sync_q[SYNC_STAGES-1];
  assign press_db = (state_q == PRESS_DB);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse   <= pulse_d;
    end
  end

  // A bounce back to the accepted level restarts the wait without re-pulsing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_DB;
          cnt_d   = '0;
        end
      end
      PRESS_DB: begin
        if (!s) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_DB;
          cnt_d   = '0;
        end
      end
      RELEASE_DB: begin
        if (s) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/battleship_input_cond.sv
// Conditions raw buttons/switches into press pulses plus a coordinate held stable across each press.
// Latency: pulse SYNC_STAGES+DB_CYCLES+1 edges after press; X/Y track switches with SYNC_STAGES+1; no backpressure.
module battleship_input_cond
  import battleship_input_cond_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnA_raw,
  input  logic       btnB_raw,
  input  logic [1:0] sw_x,
  input  logic [1:0] sw_y,
  output logic       pAb,
  output logic       pBb,
  output logic [1:0] X,
  output logic [1:0] Y
);

  logic [SYNC_STAGES-1:0][3:0] sw_sync_q;
  logic                        a_press_db, b_press_db;
  logic                        hold;

  btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_db_a (
    .clk      (clk),
    .rst      (rst),
    .raw      (btnA_raw),
    .pulse    (pAb),
    .press_db (a_press_db)
  );

  btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_db_b (
    .clk      (clk),
    .rst      (rst),
    .raw      (btnB_raw),
    .pulse    (pBb),
    .press_db (b_press_db)
  );

  // Freeze the coordinate from debounce start until the pulse has been seen.
  assign hold = a_press_db | b_press_db | pAb | pBb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_sync_q <= '0;
      X         <= '0;
      Y         <= '0;
    end else begin
      sw_sync_q <= {sw_sync_q[SYNC_STAGES-2:0], {sw_x, sw_y}};
      if (!hold) begin
        {X, Y} <= sw_sync_q[SYNC_STAGES-1];
      end
    end
  end

endmodule
